// File: rtl/tohost_monitor.sv
// Harness-side tohost decoder: turns DUT writes into pass/fail/console events
// and drives the sticky success/failure levels, with an optional idle watchdog.
module tohost_monitor #(
  parameter int unsigned             ADDR_W      = 32,
  parameter logic [ADDR_W-1:0]       TOHOST_ADDR = 32'h8000_1000,
  parameter int unsigned             TIMEOUT     = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_req_valid,
  output logic              io_req_ready,
  input  logic [ADDR_W-1:0] io_req_addr,
  input  logic [63:0]       io_req_data,
  output logic              io_putc_valid,
  input  logic              io_putc_ready,
  output logic [7:0]        io_putc_data,
  output logic              io_success,
  output logic              io_failure,
  output logic [30:0]       io_exit_code
);

  typedef enum logic [1:0] {
    S_RUN,
    S_PUTC,
    S_PASS,
    S_FAIL
  } state_e;

  localparam bit          WD_EN   = (TIMEOUT != 0);
  localparam logic [31:0] WD_LAST = 32'(TIMEOUT - 1);

  localparam logic [30:0] CODE_BAD_CMD = 31'h7FFF_FFFE;
  localparam logic [30:0] CODE_TIMEOUT = 31'h7FFF_FFFF;

  state_e      state_q, state_d;
  logic [7:0]  putc_data_q, putc_data_d;
  logic [30:0] exit_code_q, exit_code_d;
  logic [31:0] wd_q, wd_d;

  logic       req_accept;
  logic       is_tohost;
  logic [7:0] dev;
  logic [7:0] cmd;
  logic       unused_data;

  assign io_req_ready = reset && (state_q != S_PUTC);
  assign req_accept   = io_req_valid && io_req_ready;
  assign is_tohost    = (io_req_addr == TOHOST_ADDR);
  assign dev          = io_req_data[63:56];
  assign cmd          = io_req_data[55:48];
  assign unused_data  = ^io_req_data[47:32];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    state_d     = state_q;
    putc_data_d = putc_data_q;
    exit_code_d = exit_code_q;
    wd_d        = wd_q;

    if (req_accept) wd_d = '0;

    unique case (state_q)
      S_RUN: begin
        if (req_accept) begin
          // Non-tohost writes are swallowed; they only feed the watchdog.
          if (is_tohost) begin
            if (dev == 8'd0 && io_req_data[0]) begin
              if (io_req_data[31:1] == 31'd0) begin
                state_d = S_PASS;
              end else begin
                state_d     = S_FAIL;
                exit_code_d = io_req_data[31:1];
              end
            end else if (dev == 8'd1 && cmd == 8'd1) begin
              state_d     = S_PUTC;
              putc_data_d = io_req_data[7:0];
            end else begin
              state_d     = S_FAIL;
              exit_code_d = CODE_BAD_CMD;
            end
          end
        end else if (WD_EN && wd_q == WD_LAST) begin
          state_d     = S_FAIL;
          exit_code_d = CODE_TIMEOUT;
        end else if (WD_EN) begin
          wd_d = wd_q + 32'd1;
        end
      end
      S_PUTC: begin
        if (io_putc_ready) state_d = S_RUN;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: reset is synchronous and active-low, so it is tested inside the clocked block.
    if (!reset) begin
      state_q     <= S_RUN;
      putc_data_q <= '0;
      exit_code_q <= '0;
      wd_q        <= '0;
    end else begin
      state_q     <= state_d;
      putc_data_q <= putc_data_d;
      exit_code_q <= exit_code_d;
      wd_q        <= wd_d;
    end
  end

  assign io_putc_valid = (state_q == S_PUTC);
  assign io_putc_data  = putc_data_q;
  assign io_success    = (state_q == S_PASS);
  assign io_failure    = (state_q == S_FAIL);
  assign io_exit_code  = exit_code_q;

endmodule

// File: tb/tb_tohost_monitor.sv
// Directed bench for tohost_monitor: two instances (watchdog 100 / disabled) share
// stimulus and are checked every cycle against an outcome-level model.
module tb_tohost_monitor;

  localparam logic [31:0] TH = 32'h8000_1000;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_req_valid;
  logic [31:0] io_req_addr;
  logic [63:0] io_req_data;
  logic        io_putc_ready;

  logic [1:0]  rdy, pv, succ, fail;
  logic [7:0]  pd [2];
  logic [30:0] ec [2];

  always #5 clock = ~clock;

  tohost_monitor #(.ADDR_W(32), .TOHOST_ADDR(TH), .TIMEOUT(100)) u_dut_wd (
    .clock(clock), .reset(reset),
    .io_req_valid(io_req_valid), .io_req_ready(rdy[0]),
    .io_req_addr(io_req_addr), .io_req_data(io_req_data),
    .io_putc_valid(pv[0]), .io_putc_ready(io_putc_ready), .io_putc_data(pd[0]),
    .io_success(succ[0]), .io_failure(fail[0]), .io_exit_code(ec[0])
  );

  tohost_monitor #(.ADDR_W(32), .TOHOST_ADDR(TH), .TIMEOUT(0)) u_dut_nowd (
    .clock(clock), .reset(reset),
    .io_req_valid(io_req_valid), .io_req_ready(rdy[1]),
    .io_req_addr(io_req_addr), .io_req_data(io_req_data),
    .io_putc_valid(pv[1]), .io_putc_ready(io_putc_ready), .io_putc_data(pd[1]),
    .io_success(succ[1]), .io_failure(fail[1]), .io_exit_code(ec[1])
  );

  int vectors     = 0;
  int miscompares = 0;
  int handshakes  = 0;
  bit armed       = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Outcome model: what the harness must report, tracked as flags plus an idle count.
  typedef struct packed {
    logic        succ;
    logic        fail;
    logic        putc;
    logic [30:0] code;
    logic [7:0]  ch;
    logic [31:0] idle;
  } model_t;

  model_t m [2];

  function automatic int unsigned tmo(input int i);
    return (i == 0) ? 100 : 0;
  endfunction

  function automatic model_t step(input model_t s, input int unsigned to);
    model_t n = s;
    logic   acc;
    if (!reset) return '0;
    acc = io_req_valid && !s.putc;
    if (acc) n.idle = 0;
    if (s.succ || s.fail) return n;
    if (s.putc) begin
      if (io_putc_ready) n.putc = 1'b0;
      return n;
    end
    if (acc) begin
      if (io_req_addr == TH) begin
        if (io_req_data[63:56] == 8'd0 && io_req_data[0]) begin
          if (io_req_data[31:1] == 31'd0) n.succ = 1'b1;
          else begin n.fail = 1'b1; n.code = io_req_data[31:1]; end
        end else if (io_req_data[63:56] == 8'd1 && io_req_data[55:48] == 8'd1) begin
          n.putc = 1'b1;
          n.ch   = io_req_data[7:0];
        end else begin
          n.fail = 1'b1;
          n.code = 31'h7FFF_FFFE;
        end
      end
    end else if (to != 0 && s.idle + 1 == to) begin
      n.fail = 1'b1;
      n.code = 31'h7FFF_FFFF;
    end else begin
      n.idle = s.idle + 1;
    end
    return n;
  endfunction

  always @(posedge clock) begin
    for (int i = 0; i < 2; i++) m[i] <= step(m[i], tmo(i));
    if (!reset) armed <= 1'b1;
  end

  always @(negedge clock) begin
    if (armed) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("req_ready[%0d]", i), rdy[i], reset && !m[i].putc);
        check($sformatf("putc_valid[%0d]", i), pv[i], m[i].putc);
        check($sformatf("putc_data[%0d]", i), pd[i], m[i].ch);
        check($sformatf("success[%0d]", i), succ[i], m[i].succ);
        check($sformatf("failure[%0d]", i), fail[i], m[i].fail);
        check($sformatf("exit_code[%0d]", i), ec[i], m[i].code);
        check($sformatf("exclusive[%0d]", i), succ[i] && fail[i], 1'b0);
      end
      if (pv[0] && io_putc_ready) handshakes++;
    end
  end

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    check("rst_ready", rdy[0], 1'b0);
    check("rst_success", succ[0], 1'b0);
    check("rst_failure", fail[0], 1'b0);
    check("rst_code", ec[0], 31'd0);
    check("rst_putc_valid", pv[0], 1'b0);
    check("rst_putc_data", pd[0], 8'd0);
    reset = 1'b1;
  endtask

  task automatic write(input logic [31:0] addr, input logic [63:0] data);
    io_req_valid = 1'b1;
    io_req_addr  = addr;
    io_req_data  = data;
    @(posedge clock);
    #2;
    io_req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  initial begin
    int hs0;
    reset         = 1'b0;
    io_req_valid  = 1'b0;
    io_req_addr   = '0;
    io_req_data   = '0;
    io_putc_ready = 1'b1;

    // Pass, then terminal despite further writes.
    do_reset();
    write(TH, 64'h1);
    check("pass_success", succ[0], 1'b1);
    check("pass_failure", fail[0], 1'b0);
    check("pass_code", ec[0], 31'd0);
    for (int k = 0; k < 50; k++) write(TH, 64'h7);
    check("pass_held", succ[0], 1'b1);
    check("pass_held_nofail", fail[0], 1'b0);

    // Failure codes.
    do_reset();
    write(TH, 64'h7);
    check("fail7_failure", fail[0], 1'b1);
    check("fail7_code", ec[0], 31'd3);
    do_reset();
    write(TH, 64'h0);
    check("fail0_code", ec[0], 31'h7FFF_FFFE);
    do_reset();
    write(TH, 64'h0200_0000_0000_0001);
    check("baddev_code", ec[0], 31'h7FFF_FFFE);
    do_reset();
    write(32'h8000_1008, 64'h1);
    check("nontohost_ignored", succ[0], 1'b0);
    write(TH, 64'h3);
    check("fail3_code", ec[0], 31'd1);

    // Console output with backpressure, then a free-flowing byte.
    do_reset();
    hs0 = handshakes;
    io_putc_ready = 1'b0;
    write(TH, 64'h0101_0000_0000_0041);
    check("putc_valid", pv[0], 1'b1);
    check("putc_data", pd[0], 8'h41);
    check("putc_ready_low", rdy[0], 1'b0);
    for (int k = 0; k < 3; k++) begin
      idle(1);
      check("putc_hold_valid", pv[0], 1'b1);
      check("putc_hold_data", pd[0], 8'h41);
    end
    io_putc_ready = 1'b1;
    idle(1);
    check("putc_done_valid", pv[0], 1'b0);
    check("putc_done_ready", rdy[0], 1'b1);
    write(TH, 64'h0101_0000_0000_0042);
    check("putc2_data", pd[0], 8'h42);
    idle(1);
    check("putc2_done", pv[0], 1'b0);
    check("putc_handshakes", handshakes - hs0, 2);

    // Watchdog expiry exactly TIMEOUT edges after reset release.
    do_reset();
    idle(99);
    check("wd_before", fail[0], 1'b0);
    idle(1);
    check("wd_fire", fail[0], 1'b1);
    check("wd_code", ec[0], 31'h7FFF_FFFF);
    check("wd_disabled", fail[1], 1'b0);

    // Non-tohost write at cycle 99 restarts the count.
    do_reset();
    idle(98);
    write(32'h8000_1008, 64'h0);
    idle(99);
    check("wd_kick_before", fail[0], 1'b0);
    idle(1);
    check("wd_kick_fire", fail[0], 1'b1);

    // Write coincident with expiry wins.
    do_reset();
    idle(99);
    write(TH, 64'h1);
    check("wd_race_success", succ[0], 1'b1);
    check("wd_race_nofail", fail[0], 1'b0);

    // Long idle: only the watchdog instance fails.
    do_reset();
    idle(10000);
    check("nowd_idle", fail[1], 1'b0);
    check("wd_idle", fail[0], 1'b1);

    // Reset mid-PUTC and after FAIL, then a clean pass.
    do_reset();
    io_putc_ready = 1'b0;
    write(TH, 64'h0101_0000_0000_005A);
    check("mid_putc_valid", pv[0], 1'b1);
    reset = 1'b0;
    @(posedge clock);
    #2;
    check("mid_putc_drop", pv[0], 1'b0);
    check("mid_putc_data", pd[0], 8'd0);
    check("mid_putc_ready", rdy[0], 1'b0);
    reset = 1'b1;
    io_putc_ready = 1'b1;
    write(TH, 64'h0);
    check("refail", fail[0], 1'b1);
    reset = 1'b0;
    @(posedge clock);
    #2;
    check("fail_clear", fail[0], 1'b0);
    check("fail_clear_code", ec[0], 31'd0);
    reset = 1'b1;
    write(TH, 64'h1);
    check("repass", succ[0], 1'b1);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tohost_monitor.md
# tohost_monitor

Sits inside the test harness. Watches the harness-side tohost write port of the device under test and decodes each write into one of three outcomes: pass/fail termination, console character output, or a protocol error. Drives the harness `io_success` level seen by the test driver and a separate failure level with an exit code. An optional inactivity watchdog forces a failure when the DUT stops writing.

## Interface
- `ADDR_W`, 32: request address width.
- `TOHOST_ADDR`, 32'h8000_1000: address decoded as tohost.
- `TIMEOUT`, 0: watchdog limit in cycles, counted since the last accepted write; 0 disables the watchdog; must be < 2^32.

Ports:
- `clock`  in  1  sole clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-low; state is cleared on any rising edge where `reset`=0.
- `io_req_valid`  in  1  write request valid.
- `io_req_ready`  out  1  write request accepted when valid && ready.
- `io_req_addr`  in  ADDR_W  write address.
- `io_req_data`  in  64  write data.
- `io_putc_valid`  out  1  console byte valid.
- `io_putc_ready`  in  1  console sink ready.
- `io_putc_data`  out  8  console byte.
- `io_success`  out  1  sticky pass indication.
- `io_failure`  out  1  sticky fail indication.
- `io_exit_code`  out  31  exit code; meaningful when `io_failure`=1.

## Operation
- States: RUN, PUTC, PASS, FAIL. Reset enters RUN.
- `io_req_ready`:
  - 1 in RUN, PASS and FAIL.
  - 0 in PUTC.
  - Forced to 0 while `reset`=0.
- An accepted write to an address other than `TOHOST_ADDR` is consumed and ignored, but it still clears the watchdog.
- Accepted tohost write in RUN, with device = data[63:56], cmd = data[55:48]:
  - device 0 and data[0]=1: code = data[31:1]. Code 0 → PASS. Otherwise → FAIL with `io_exit_code`=code.
  - device 1, cmd 1: → PUTC. `io_putc_data` is latched from data[7:0].
  - Any other value, including device 0 with data[0]=0: → FAIL, `io_exit_code`=31'h7FFF_FFFE.
- PUTC:
  - `io_putc_valid`=1. `io_putc_data` is held stable.
  - On `io_putc_ready`=1, return to RUN.
- PASS and FAIL are terminal until reset. Writes in these states are accepted and discarded. Outputs are frozen.
- Watchdog (only when `TIMEOUT`>0):
  - 32-bit counter, cleared on reset and on every accepted write.
  - Increments on each RUN cycle without an accepted write. Holds in PUTC, PASS and FAIL.
  - In RUN, with counter == `TIMEOUT`-1 and no accepted write this cycle → FAIL, `io_exit_code`=31'h7FFF_FFFF.
- Simultaneous events: an accepted write in the same cycle as watchdog expiry takes priority; the write is decoded and the counter is cleared.
- Invariant: `io_success` and `io_failure` are never both 1.

## Timing
- Reset values: `io_success`=0, `io_failure`=0, `io_exit_code`=0, `io_putc_valid`=0, `io_putc_data`=0, `io_req_ready`=0 while reset is asserted.
- All outputs except `io_req_ready` are registered.
- Write accepted at edge N → `io_success`/`io_failure`/`io_putc_valid` update at N+1; one-cycle latency.
- `io_req_ready` is a combinational function of state, so it is 0 from cycle N+1 through the cycle `io_putc_ready` is sampled 1.
- Minimum PUTC occupancy is 1 cycle, so back-to-back putc writes sustain one byte per 2 cycles.
- With no writes after reset release at edge R, the watchdog FAIL is visible at R+`TIMEOUT`.
- Reset asserted mid-PUTC: on that edge `io_putc_valid` drops to 0 with no handshake and the byte is lost.
- Reset asserted in PASS/FAIL: both levels clear on that edge.

## Test plan
- Pass: write 64'h1 to `TOHOST_ADDR` → `io_success`=1 next cycle, `io_failure`=0, `io_exit_code`=0, held for 50 further cycles despite extra writes.
- Fail code: write 64'h7 → `io_failure`=1 next cycle, `io_exit_code`=3. Write 64'h0 → `io_exit_code`=31'h7FFF_FFFE.
- Putc backpressure: write 64'h0101_0000_0000_0041 with `io_putc_ready` low for 3 cycles → `io_putc_valid`=1 and `io_putc_data`=8'h41 held 4 cycles, `io_req_ready`=0 meanwhile, then RUN resumes. A second putc (8'h42) with sink always ready → exactly one byte per handshake.
- Watchdog, `TIMEOUT`=100:
  - No writes → `io_failure` at reset-release+100, `io_exit_code`=31'h7FFF_FFFF.
  - Non-tohost write at cycle 99 → no failure before cycle 199.
  - Write coincident with expiry → write decoded, no timeout.
- `TIMEOUT`=0: 10,000 idle cycles → `io_failure` stays 0.
- Reset mid-operation: assert reset during PUTC and again after FAIL → all outputs return to reset values on that edge. A subsequent 64'h1 write yields PASS.
